msx_mouse_encoder: RTL and testbench

//  Converts PS/2 mouse packets (ps2mouse deltas/buttons) into the MSX mouse nibble protocol on joystick port A.

---
 rtl/msx_mouse_encoder.sv | 113 +++++++++++
 tb/tb_msx_mouse_encoder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/msx_mouse_encoder.sv
// PS/2 mouse to MSX mouse nibble protocol on joystick port A.
// Accumulates deltas between reads and serves X/Y as four nibbles clocked by STR toggles.
module msx_mouse_encoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic [1:0] mouse_btn,
  input  logic [5:0] joy_in,
  input  logic       msx_str,
  output logic [5:0] port_out,
  output logic       mouse_active
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t                 r_state, w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_str_d;
  logic                   r_edge;
  logic                   w_edge;
  logic [7:0]             r_acc_x, r_acc_y;
  logic [7:0]             r_lx, r_ly;
  logic [3:0]             r_nib, w_nib;
  logic [CW-1:0]          r_cnt;
  logic                   w_active_nx;
  logic                   w_snap;
  logic [7:0]             w_base_x, w_base_y;
  logic [9:0]             w_sum_x, w_sum_y;

  function automatic logic [7:0] sat8(input logic [9:0] s);
    if (!s[9] && (s[8:7] != 2'b00))      sat8 = 8'h7F;
    else if (s[9] && (s[8:7] != 2'b11))  sat8 = 8'h80;
    else                                 sat8 = s[7:0];
  endfunction

  assign w_edge = r_sync[SYNC_STAGES-1] ^ r_str_d;
  assign w_snap = r_edge && (r_state == S0);

  // A strobe landing on the S0 read sees an already-cleared accumulator
  assign w_base_x = w_snap ? 8'd0 : r_acc_x;
  assign w_base_y = w_snap ? 8'd0 : r_acc_y;
  assign w_sum_x  = {{2{w_base_x[7]}}, w_base_x} - {mouse_dx[8], mouse_dx};
  assign w_sum_y  = {{2{w_base_y[7]}}, w_base_y} + {mouse_dy[8], mouse_dy};

  assign w_active_nx = mouse_strobe ? 1'b1 : ((joy_in != 6'h3F) ? 1'b0 : mouse_active);

  always_comb begin
    w_state_nx = r_state;
    w_nib      = r_nib;
    if (r_edge) begin
      case (r_state)
        S0: begin w_nib = r_acc_x[7:4]; w_state_nx = S1; end
        S1: begin w_nib = r_lx[3:0];    w_state_nx = S2; end
        S2: begin w_nib = r_ly[7:4];    w_state_nx = S3; end
        default: begin w_nib = r_ly[3:0]; w_state_nx = S0; end
      endcase
    end else if (r_cnt == CW'(1)) begin
      w_state_nx = S0;
    end
    if (mouse_active && !w_active_nx) w_state_nx = S0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S0;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sync       <= '0;
      r_str_d      <= 1'b0;
      r_edge       <= 1'b0;
      r_acc_x      <= 8'd0;
      r_acc_y      <= 8'd0;
      r_lx         <= 8'd0;
      r_ly         <= 8'd0;
      r_nib        <= 4'd0;
      r_cnt        <= '0;
      mouse_active <= 1'b0;
      port_out     <= 6'h3F;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], msx_str};
      r_str_d <= r_sync[SYNC_STAGES-1];
      r_edge  <= w_edge;
      r_nib   <= w_nib;

      if (w_snap) begin
        r_lx <= r_acc_x;
        r_ly <= r_acc_y;
      end
      if (mouse_strobe) begin
        r_acc_x <= sat8(w_sum_x);
        r_acc_y <= sat8(w_sum_y);
      end else if (w_snap) begin
        r_acc_x <= 8'd0;
        r_acc_y <= 8'd0;
      end

      if (r_edge)                 r_cnt <= CW'(TIMEOUT_CYCLES);
      else if (r_cnt != '0)       r_cnt <= r_cnt - CW'(1);

      mouse_active <= w_active_nx;
      if (w_active_nx) port_out <= {~mouse_btn, w_nib};
      else             port_out <= joy_in;
    end
  end
endmodule

// File: tb/tb_msx_mouse_encoder.sv
// Directed bench for msx_mouse_encoder with hand-computed nibble sequences.
module tb_msx_mouse_encoder;
  localparam int TMO = 200;

  logic       clk_sys = 0;
  logic       reset = 1;
  logic       mouse_strobe = 0;
  logic [8:0] mouse_dx = 0, mouse_dy = 0;
  logic [1:0] mouse_btn = 0;
  logic [5:0] joy_in = 6'h3F;
  logic       msx_str = 0;
  logic [5:0] port_out;
  logic       mouse_active;

  int checks = 0;
  int errors = 0;

  msx_mouse_encoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .mouse_strobe(mouse_strobe),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_btn(mouse_btn),
    .joy_in(joy_in), .msx_str(msx_str), .port_out(port_out),
    .mouse_active(mouse_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [8:0] dx, input logic [8:0] dy);
    @(negedge clk_sys);
    mouse_dx = dx; mouse_dy = dy; mouse_strobe = 1;
    @(negedge clk_sys);
    mouse_strobe = 0;
  endtask

  task automatic toggle_chk(input string tag, input logic [5:0] exp);
    @(negedge clk_sys);
    msx_str = ~msx_str;
    repeat (20) @(negedge clk_sys);
    chk(tag, {2'b00, port_out}, {2'b00, exp});
  endtask

  initial begin
    // 1: reset
    repeat (3) @(negedge clk_sys);
    reset = 0;
    chk("rst_port", {2'b00, port_out}, 8'h3F);
    chk("rst_active", {7'd0, mouse_active}, 8'h00);
    toggle_chk("t1_tog0", 6'h3F);
    toggle_chk("t1_tog1", 6'h3F);
    @(negedge clk_sys); reset = 1;
    @(negedge clk_sys); reset = 0;

    // 2: dx=+5, dy=+3 -> acc_x=FB, acc_y=03
    strobe(9'd5, 9'd3);
    chk("t2_active", {7'd0, mouse_active}, 8'h01);
    chk("t2_idle", {2'b00, port_out}, 8'h30);
    toggle_chk("t2_n0", 6'h3F);
    toggle_chk("t2_n1", 6'h3B);
    toggle_chk("t2_n2", 6'h30);
    toggle_chk("t2_n3", 6'h33);

    // 3: saturation at +127, left button held
    mouse_btn = 2'b01;
    strobe(9'h19C, 9'd0);
    strobe(9'h19C, 9'd0);
    strobe(9'h19C, 9'd0);
    toggle_chk("t3_n0", 6'h27);
    toggle_chk("t3_n1", 6'h2F);
    toggle_chk("t3_n2", 6'h20);
    toggle_chk("t3_n3", 6'h20);
    mouse_btn = 2'b00;

    // 4: timeout returns sequencer to S0
    toggle_chk("t4_n0", 6'h30);
    toggle_chk("t4_n1", 6'h30);
    strobe(9'h1CB, 9'd0);              // acc_x = 0x35
    repeat (TMO + 5) @(negedge clk_sys);
    toggle_chk("t4_restart", 6'h33);
    toggle_chk("t4_r1", 6'h35);
    toggle_chk("t4_r2", 6'h30);
    toggle_chk("t4_r3", 6'h30);

    // 5: joystick passthrough
    @(negedge clk_sys); joy_in = 6'b111110;
    @(negedge clk_sys);
    chk("t5_active", {7'd0, mouse_active}, 8'h00);
    chk("t5_port", {2'b00, port_out}, 8'h3E);
    joy_in = 6'h3F;
    @(negedge clk_sys);
    chk("t5_release", {2'b00, port_out}, 8'h3F);

    // 6: strobe coincident with S0 edge
    strobe(9'h1F0, 9'd0);              // acc_x = 0x10
    @(negedge clk_sys);
    msx_str = ~msx_str;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    mouse_dx = 9'h1FE; mouse_dy = 9'd0; mouse_strobe = 1;
    @(negedge clk_sys);
    mouse_strobe = 0;
    repeat (18) @(negedge clk_sys);
    chk("t6_n0", {2'b00, port_out}, 8'h31);
    toggle_chk("t6_n1", 6'h30);
    toggle_chk("t6_n2", 6'h30);
    toggle_chk("t6_n3", 6'h30);
    toggle_chk("t6_next0", 6'h30);
    toggle_chk("t6_next1", 6'h32);

    // 7: reset mid-sequence (state S2, acc_x loaded)
    strobe(9'h1B0, 9'd0);              // acc_x = 0x50
    @(negedge clk_sys); reset = 1;
    @(negedge clk_sys); reset = 0;
    chk("t7_port", {2'b00, port_out}, 8'h3F);
    chk("t7_active", {7'd0, mouse_active}, 8'h00);
    strobe(9'd0, 9'd0);
    toggle_chk("t7_n0", 6'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
